// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU result mux: captures result/op with
// zero/neg flags into a 2-entry skid buffer and counts retired results.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero,
  output logic             out_neg,
  input  logic             clear_count,
  output logic [CNTW-1:0]  retired_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] m_result_q, s_result_q;
  logic [OPW-1:0]   m_op_q, s_op_q;
  logic             m_zero_q, m_neg_q, s_zero_q, s_neg_q;
  logic [CNTW-1:0]  cnt_q;

  logic accept, retire;
  logic load_m_in, load_m_s, load_s;
  logic in_zero, in_neg;

  assign accept  = in_valid & in_ready_q;
  assign retire  = out_valid & out_ready;
  assign in_zero = (in_result == '0);
  assign in_neg  = in_result[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_m_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && retire) begin
          load_m_in = 1'b1;
        end else if (accept) begin
          state_d = FULL;
          load_s  = 1'b1;
        end else if (retire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (retire) begin
          state_d  = ONE;
          load_m_s = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is registered from the next state, so out_ready never reaches it combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      m_result_q <= '0;
      m_op_q     <= '0;
      m_zero_q   <= 1'b0;
      m_neg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_m_in) begin
        m_result_q <= in_result;
        m_op_q     <= in_op;
        m_zero_q   <= in_zero;
        m_neg_q    <= in_neg;
      end else if (load_m_s) begin
        m_result_q <= s_result_q;
        m_op_q     <= s_op_q;
        m_zero_q   <= s_zero_q;
        m_neg_q    <= s_neg_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_s) begin
      s_result_q <= in_result;
      s_op_q     <= in_op;
      s_zero_q   <= in_zero;
      s_neg_q    <= in_neg;
    end
  end

  // Clear has priority over a same-cycle retire; the count sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_count) begin
      cnt_q <= '0;
    end else if (retire && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != EMPTY);
  assign out_result    = m_result_q;
  assign out_op        = m_op_q;
  assign out_zero      = m_zero_q;
  assign out_neg       = m_neg_q;
  assign retired_count = cnt_q;

endmodule
